// File: rtl/johnson_decoder.sv
// Johnson-code decoder: classifies each sample against the previous code and tracks sequence lock.
// Optional saturating error counter, enabled by defining JDEC_ERRCNT_EN.
module johnson_decoder #(
  parameter int  WIDTH    = 4,
  parameter int  LOCK_CNT = 3,
  localparam int IW       = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [IW-1:0]    out_index,
  output logic             out_illegal,
  output logic             out_skip,
  output logic             locked,
  output logic [7:0]       err_count
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // 2*WIDTH truncated to IW bits; modular subtraction still yields 2*WIDTH - ones
  localparam logic [IW-1:0] TWO_W  = IW'(2*WIDTH);
  localparam logic [3:0]    LOCK_C = 4'(LOCK_CNT);

  function automatic logic is_legal(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] t;
    t = c[WIDTH-1] ? ~c : c;
    return ((t & (t + {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
  endfunction

  function automatic logic [IW-1:0] code_index(input logic [WIDTH-1:0] c);
    logic [IW-1:0] ones;
    logic [IW-1:0] idx;
    ones = {IW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{(IW-1){1'b0}}, c[i]};
    end
    if (c[WIDTH-1]) begin
      idx = TWO_W - ones;
    end else begin
      idx = ones;
    end
    return idx;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       mcnt_r;
  logic [3:0]       mcnt_nxt_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] succ_code_s;
  logic             legal_s;
  logic             hold_s;
  logic             succ_s;
  logic             skip_s;
  logic             err_s;
  logic [IW-1:0]    idx_s;

  // Classify the incoming sample against the stored previous code
  always_comb begin
    succ_code_s = {prev_r[WIDTH-2:0], ~prev_r[WIDTH-1]};
    legal_s     = is_legal(in_code);
    hold_s      = legal_s && (in_code == prev_r);
    succ_s      = legal_s && (in_code == succ_code_s);
    skip_s      = legal_s && !hold_s && !succ_s;
    err_s       = in_valid && (!legal_s || skip_s);
    if (legal_s) begin
      idx_s = code_index(in_code);
    end else begin
      idx_s = {IW{1'b0}};
    end
  end

  // Lock FSM next-state and match counter
  always_comb begin
    state_nxt_s = state_r;
    mcnt_nxt_s  = mcnt_r;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (!legal_s || skip_s) begin
            mcnt_nxt_s = 4'd0;
          end else if (succ_s) begin
            if ((mcnt_r + 4'd1) == LOCK_C) begin
              state_nxt_s = LOCKED;
              mcnt_nxt_s  = 4'd0;
            end else begin
              mcnt_nxt_s = mcnt_r + 4'd1;
            end
          end else begin
            mcnt_nxt_s = mcnt_r;
          end
        end
        LOCKED: begin
          if (!legal_s || skip_s) begin
            state_nxt_s = HUNT;
            mcnt_nxt_s  = 4'd0;
          end else begin
            state_nxt_s = LOCKED;
          end
        end
        default: begin
          state_nxt_s = HUNT;
          mcnt_nxt_s  = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      mcnt_nxt_s  = mcnt_r;
    end
  end

  // State, history and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= HUNT;
      mcnt_r      <= 4'd0;
      prev_r      <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      out_index   <= {IW{1'b0}};
      out_illegal <= 1'b0;
      out_skip    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mcnt_r    <= mcnt_nxt_s;
      locked    <= (state_nxt_s == LOCKED);
      out_valid <= in_valid;
      if (in_valid) begin
        out_index   <= idx_s;
        out_illegal <= !legal_s;
        out_skip    <= skip_s;
        if (legal_s) begin
          prev_r <= in_code;
        end
      end
    end
  end

`ifdef JDEC_ERRCNT_EN
  logic [7:0] err_count_r;

  // Saturating error counter; a clear coinciding with an error leaves one count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_r <= 8'd0;
    end else if (err_clr) begin
      err_count_r <= err_s ? 8'd1 : 8'd0;
    end else if (err_s && (err_count_r != 8'd255)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

  assign err_count = err_count_r;
`else
  logic errcnt_unused_s;

  assign errcnt_unused_s = err_clr ^ err_s;
  assign err_count       = 8'd0;
`endif

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the Johnson code width in bits; legal range is 2..16.
REQ-002 Parameter LOCK_CNT, default 3, SHALL set the number of consecutive in-sequence codes required to lock; legal range is 1..15.
REQ-003 Localparam IW SHALL equal $clog2(2*WIDTH), which is the index width (3 when WIDTH=4).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL qualify in_code for the current cycle.
REQ-007 in_code  input  WIDTH  SHALL carry the Johnson-coded sample.
REQ-008 err_clr  input  1  SHALL synchronously clear err_count.
REQ-009 out_valid  output  1  SHALL be a one-cycle pulse marking the decoded result.
REQ-010 out_index  output  IW  SHALL carry the binary index of the decoded code.
REQ-011 out_illegal  output  1  SHALL flag that the sample is not a legal Johnson code.
REQ-012 out_skip  output  1  SHALL flag a legal code that is neither a hold nor a successor.
REQ-013 locked  output  1  SHALL be high while the FSM is in LOCKED.
REQ-014 err_count  output  8  SHALL report the saturating error count.

Function
REQ-015 The Johnson sequence SHALL be next = {code[WIDTH-2:0], ~code[WIDTH-1]}, starting from all-zeros (WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000, then wrap to 0000).
REQ-016 A code SHALL be legal iff its ones are contiguous and anchored at the LSB when MSB=0, or anchored at the MSB when MSB=1.
REQ-017 For a legal code, out_index SHALL equal popcount(code) when MSB=0, and 2*WIDTH-popcount(code) when MSB=1.
REQ-018 For an illegal code, out_index SHALL be 0.
REQ-019 All outputs SHALL be registered, with latency exactly 1 cycle from the in_valid sample to out_valid.
REQ-020 When in_valid=0, out_valid SHALL be 0 in the next cycle; out_index, out_illegal and out_skip SHALL hold their values; FSM and history SHALL be unchanged.
REQ-021 Each accepted sample SHALL be classified as exactly one of the following, compared against the stored previous code prev:
- illegal;
- hold (equal to prev);
- successor (equal to next(prev));
- skip (any other legal code).
REQ-022 prev SHALL update to in_code on every accepted legal sample and SHALL NOT update on an illegal sample.
REQ-023 The FSM SHALL have states HUNT and LOCKED, plus a match counter mcnt of width 4.
REQ-024 In HUNT:
- successor increments mcnt;
- hold leaves mcnt unchanged;
- illegal or skip clears mcnt to 0.
REQ-025 In HUNT, when a successor raises mcnt to LOCK_CNT, the FSM SHALL move to LOCKED on that edge, and mcnt SHALL clear.
REQ-026 In LOCKED, successor and hold SHALL stay in LOCKED.
REQ-027 In LOCKED, illegal or skip SHALL move to HUNT with mcnt=0, and locked SHALL deassert on the same edge as out_valid for that sample.
REQ-028 The wrap from code 2*WIDTH-1 to code 0 SHALL count as a successor.
REQ-029 The first accepted sample after reset SHALL be compared against prev=0, so all-zeros is a hold and 0001 is a successor.
REQ-030 An error event SHALL be any accepted sample classified illegal or skip in either state.

Reset
REQ-031 Reset assertion SHALL immediately force:
- out_valid=0, out_index=0, out_illegal=0, out_skip=0, locked=0, err_count=0;
- FSM state HUNT, mcnt=0, prev=0.
REQ-032 Reset asserted mid-stream SHALL discard any in-flight sample, and no out_valid SHALL appear for it.
REQ-033 Reset release SHALL be usable on any edge; the first rising edge after release may accept a sample.

Configuration
REQ-034 With macro JDEC_ERRCNT_EN defined:
- err_count SHALL increment by 1 per error event and saturate at 255;
- err_clr SHALL set it to 0;
- simultaneous err_clr and an error event SHALL yield 1.
REQ-035 Without JDEC_ERRCNT_EN, err_count SHALL be constant 0, err_clr SHALL be ignored, and no counter flops SHALL be inferred.

Verification
REQ-036 Reset, then feed 0001,0011,0111 with in_valid=1 on consecutive cycles -> out_index 1,2,3; locked rises one cycle after the 0111 sample; err_count=0.
REQ-037 While locked, feed 1000 then 0000 -> out_index 7 then 0; both classified successor; locked stays 1.
REQ-038 While locked at 0011, feed 0101 -> out_illegal=1, out_index=0, locked=0; err_count=1; prev remains 0011, so a following 0111 is a successor.
REQ-039 While locked at 0011, feed 1110 -> out_skip=1, out_index=5, locked=0; err_count increments.
REQ-040 With JDEC_ERRCNT_EN, apply 300 consecutive illegal samples -> err_count=255; then err_clr with one more illegal sample -> err_count=1.
REQ-041 Mid-stream, with locked=1, toggle in_valid 1-0-1 and pulse reset low for half a cycle -> outputs clear immediately; out_valid=0 for the interrupted sample; the next 0001 gives mcnt=1 and locked=0.
